// File: rtl/pong_rally_ctrl.sv
// Pong rally sequencer: detects wall, paddle and goal events on the ball position and
// issues held bounce commands to the ball engine, keeps score and times the serve pause.
module pong_rally_ctrl #(
   parameter int unsigned SCREEN_X     = 640,
   parameter int unsigned SCREEN_Y     = 480,
   parameter int unsigned BALL_SIZE    = 12,
   parameter int unsigned PAD_W        = 8,
   parameter int unsigned PAD_H        = 64,
   parameter int unsigned LPAD_X       = 20,
   parameter int unsigned RPAD_X       = 620,
   parameter int unsigned WALL_T       = 2,
   parameter int unsigned SERVE_CYCLES = 25000000,
   parameter int unsigned WIN_SCORE    = 9
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       start,
   input  logic [9:0] ball_x,
   input  logic [9:0] ball_y,
   input  logic [9:0] paddle_l_y,
   input  logic [9:0] paddle_r_y,
   output logic [1:0] bounce,
   output logic [3:0] score_l,
   output logic [3:0] score_r,
   output logic       point_l,
   output logic       point_r,
   output logic       game_over
);

   typedef enum logic [2:0] {S_IDLE, S_SERVE, S_PLAY, S_HOLD, S_GAME_OVER} state_t;

   localparam logic [1:0]  CMD_NONE  = 2'b00;
   localparam logic [1:0]  CMD_PAD   = 2'b01;
   localparam logic [1:0]  CMD_WALL  = 2'b10;
   localparam logic [1:0]  CMD_SERVE = 2'b11;

   localparam logic [10:0] BSZ       = 11'(BALL_SIZE);
   localparam logic [10:0] PH        = 11'(PAD_H);
   localparam logic [10:0] WALL_LO   = 11'(WALL_T);
   localparam logic [10:0] WALL_HI   = 11'(SCREEN_Y - WALL_T);
   localparam logic [10:0] PAD_L_LO  = 11'(LPAD_X);
   localparam logic [10:0] PAD_L_HI  = 11'(LPAD_X + PAD_W);
   localparam logic [10:0] PAD_R_LO  = 11'(RPAD_X);
   localparam logic [10:0] PAD_R_HI  = 11'(RPAD_X + PAD_W);
   localparam logic [10:0] GOAL_X    = 11'(SCREEN_X);
   localparam logic [24:0] SERVE_END = 25'(SERVE_CYCLES - 1);
   localparam logic [3:0]  WIN       = 4'(WIN_SCORE);

   state_t      state, state_d;
   logic [1:0]  bounce_d;
   logic [3:0]  score_l_d, score_r_d;
   logic        point_l_d, point_r_d, game_over_d;
   logic [24:0] serve_cnt, serve_cnt_d;
   logic        mask_pad, mask_pad_d, mask_wall, mask_wall_d;
   logic [9:0]  lat_x, lat_x_d, lat_y, lat_y_d;

   // Sums are widened to 11 bits so edge-of-screen positions never wrap.
   logic [10:0] bx, by, bx_end, by_end, pl_top, pr_top, pl_bot, pr_bot;
   logic        hit_wall, hit_pad_l, hit_pad_r, hit_pad, goal_l, goal_r, moved;

   assign bx     = {1'b0, ball_x};
   assign by     = {1'b0, ball_y};
   assign bx_end = bx + BSZ;
   assign by_end = by + BSZ;
   assign pl_top = {1'b0, paddle_l_y};
   assign pr_top = {1'b0, paddle_r_y};
   assign pl_bot = pl_top + PH;
   assign pr_bot = pr_top + PH;

   assign hit_wall  = (by <= WALL_LO) || (by_end >= WALL_HI);
   assign hit_pad_l = (bx <= PAD_L_HI) && (bx > PAD_L_LO) && (by_end > pl_top) && (by < pl_bot);
   assign hit_pad_r = (bx_end >= PAD_R_LO) && (bx_end < PAD_R_HI) && (by_end > pr_top) && (by < pr_bot);
   assign hit_pad   = hit_pad_l || hit_pad_r;
   assign goal_r    = bx_end >= GOAL_X;
   assign goal_l    = ball_x == 10'd0;
   assign moved     = (ball_x != lat_x) || (ball_y != lat_y);

   // NOTE: sequential state uses non-blocking assignments so every register samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= S_IDLE;
         bounce    <= CMD_SERVE;
         score_l   <= '0;
         score_r   <= '0;
         point_l   <= 1'b0;
         point_r   <= 1'b0;
         game_over <= 1'b0;
         serve_cnt <= '0;
         mask_pad  <= 1'b0;
         mask_wall <= 1'b0;
         lat_x     <= '0;
         lat_y     <= '0;
      end else begin
         state     <= state_d;
         bounce    <= bounce_d;
         score_l   <= score_l_d;
         score_r   <= score_r_d;
         point_l   <= point_l_d;
         point_r   <= point_r_d;
         game_over <= game_over_d;
         serve_cnt <= serve_cnt_d;
         mask_pad  <= mask_pad_d;
         mask_wall <= mask_wall_d;
         lat_x     <= lat_x_d;
         lat_y     <= lat_y_d;
      end
   end

   // NOTE: every signal gets a default before the case so no path leaves one
   // unassigned, which would infer a latch.
   always_comb begin
      state_d     = state;
      bounce_d    = bounce;
      score_l_d   = score_l;
      score_r_d   = score_r;
      point_l_d   = 1'b0;
      point_r_d   = 1'b0;
      game_over_d = game_over;
      serve_cnt_d = serve_cnt;
      mask_pad_d  = mask_pad && hit_pad;
      mask_wall_d = mask_wall && hit_wall;
      lat_x_d     = lat_x;
      lat_y_d     = lat_y;

      case (state)
         S_IDLE: begin
            bounce_d = CMD_SERVE;
            if (start) begin
               state_d     = S_SERVE;
               serve_cnt_d = '0;
            end
         end
         S_SERVE: begin
            bounce_d = CMD_SERVE;
            if (serve_cnt == SERVE_END) begin
               state_d     = S_PLAY;
               bounce_d    = CMD_NONE;
               serve_cnt_d = '0;
               mask_pad_d  = 1'b0;
               mask_wall_d = 1'b0;
            end else begin
               serve_cnt_d = serve_cnt + 25'd1;
            end
         end
         S_PLAY: begin
            bounce_d = CMD_NONE;
            lat_x_d  = ball_x;
            lat_y_d  = ball_y;
            if (goal_r) begin
               score_l_d = (score_l == WIN) ? score_l : score_l + 4'd1;
               point_l_d = 1'b1;
               bounce_d  = CMD_SERVE;
               state_d   = S_HOLD;
            end else if (goal_l) begin
               score_r_d = (score_r == WIN) ? score_r : score_r + 4'd1;
               point_r_d = 1'b1;
               bounce_d  = CMD_SERVE;
               state_d   = S_HOLD;
            end else if (hit_pad && !mask_pad) begin
               bounce_d = CMD_PAD;
               state_d  = S_HOLD;
            end else if (hit_wall && !mask_wall) begin
               bounce_d = CMD_WALL;
               state_d  = S_HOLD;
            end
         end
         S_HOLD: begin
            // The held command itself tells which class of event is being consumed.
            if (moved) begin
               case (bounce)
                  CMD_PAD: begin
                     mask_pad_d = 1'b1;
                     bounce_d   = CMD_NONE;
                     state_d    = S_PLAY;
                  end
                  CMD_WALL: begin
                     mask_wall_d = 1'b1;
                     bounce_d    = CMD_NONE;
                     state_d     = S_PLAY;
                  end
                  default: begin
                     if (score_l == WIN || score_r == WIN) begin
                        state_d     = S_GAME_OVER;
                        game_over_d = 1'b1;
                     end else begin
                        state_d     = S_SERVE;
                        serve_cnt_d = '0;
                     end
                  end
               endcase
            end
         end
         S_GAME_OVER: begin
            bounce_d    = CMD_SERVE;
            game_over_d = 1'b1;
            if (start) begin
               score_l_d   = '0;
               score_r_d   = '0;
               game_over_d = 1'b0;
               state_d     = S_SERVE;
               serve_cnt_d = '0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_pong_rally_ctrl.sv
// Directed bench for pong_rally_ctrl with a short serve pause; each task drives one
// scenario and compares outputs one time unit after the rising edge.
module tb_pong_rally_ctrl;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic [9:0] ball_x = 10'd320;
   logic [9:0] ball_y = 10'd240;
   logic [9:0] paddle_l_y = 10'd0;
   logic [9:0] paddle_r_y = 10'd0;
   logic [1:0] bounce;
   logic [3:0] score_l, score_r;
   logic       point_l, point_r, game_over;

   int errors = 0;
   int checks = 0;

   pong_rally_ctrl #(.SERVE_CYCLES(8)) dut (
      .clock(clock), .reset(reset), .start(start),
      .ball_x(ball_x), .ball_y(ball_y),
      .paddle_l_y(paddle_l_y), .paddle_r_y(paddle_r_y),
      .bounce(bounce), .score_l(score_l), .score_r(score_r),
      .point_l(point_l), .point_r(point_r), .game_over(game_over)
   );

   always #5 clock = ~clock;

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // Called right after the edge that entered SERVE: 7 more cycles of 11, then 00.
   task automatic serve_wait(input string tag);
      for (int i = 0; i < 7; i++) begin
         step();
         checks++;
         if (bounce !== 2'b11) begin
            errors++;
            $display("FAIL %s_serve_hold[%0d]: bounce=%b expected 11", tag, i, bounce);
         end
      end
      step();
      checks++;
      if (bounce !== 2'b00) begin
         errors++;
         $display("FAIL %s_serve_release: bounce=%b expected 00", tag, bounce);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      step();
      step();
      checks++;
      if ({bounce, score_l, score_r, point_l, point_r, game_over} !== {2'b11, 4'd0, 4'd0, 3'b000}) begin
         errors++;
         $display("FAIL reset_values: bounce=%b sl=%0d sr=%0d pl=%b pr=%b go=%b expected 11/0/0/0/0/0",
                  bounce, score_l, score_r, point_l, point_r, game_over);
      end
      reset = 1'b0;
      step();
      step();
      checks++;
      if (bounce !== 2'b11) begin
         errors++;
         $display("FAIL idle_bounce: bounce=%b expected 11", bounce);
      end
   endtask

   task automatic test_serve();
      start = 1'b1;
      step();
      start = 1'b0;
      checks++;
      if (bounce !== 2'b11) begin
         errors++;
         $display("FAIL serve_entry: bounce=%b expected 11", bounce);
      end
      serve_wait("start");
      checks++;
      if (score_l !== 4'd0 || score_r !== 4'd0) begin
         errors++;
         $display("FAIL serve_scores: sl=%0d sr=%0d expected 0/0", score_l, score_r);
      end
   endtask

   task automatic test_wall();
      ball_x = 10'd320;
      ball_y = 10'd466;
      step();
      checks++;
      if (bounce !== 2'b10) begin
         errors++;
         $display("FAIL wall_issue: bounce=%b expected 10", bounce);
      end
      for (int i = 0; i < 5; i++) begin
         step();
         checks++;
         if (bounce !== 2'b10) begin
            errors++;
            $display("FAIL wall_hold[%0d]: bounce=%b expected 10", i, bounce);
         end
      end
      ball_y = 10'd467;
      step();
      checks++;
      if (bounce !== 2'b00) begin
         errors++;
         $display("FAIL wall_consume: bounce=%b expected 00", bounce);
      end
      for (int i = 0; i < 4; i++) begin
         step();
         checks++;
         if (bounce !== 2'b00) begin
            errors++;
            $display("FAIL wall_masked[%0d]: bounce=%b expected 00", i, bounce);
         end
      end
      ball_y = 10'd465;
      step();
      checks++;
      if (bounce !== 2'b00) begin
         errors++;
         $display("FAIL wall_clear_edge: bounce=%b expected 00", bounce);
      end
      ball_y = 10'd240;
      step();
   endtask

   task automatic test_paddle();
      ball_x = 10'd608;
      ball_y = 10'd200;
      paddle_r_y = 10'd300;
      step();
      step();
      checks++;
      if (bounce !== 2'b00) begin
         errors++;
         $display("FAIL paddle_miss: bounce=%b expected 00", bounce);
      end
      paddle_r_y = 10'd180;
      step();
      checks++;
      if (bounce !== 2'b01) begin
         errors++;
         $display("FAIL paddle_issue: bounce=%b expected 01", bounce);
      end
      ball_x = 10'd609;
      step();
      checks++;
      if (bounce !== 2'b00) begin
         errors++;
         $display("FAIL paddle_consume: bounce=%b expected 00", bounce);
      end
      step();
      checks++;
      if (bounce !== 2'b00) begin
         errors++;
         $display("FAIL paddle_masked: bounce=%b expected 00", bounce);
      end
      ball_x = 10'd320;
      ball_y = 10'd240;
      paddle_r_y = 10'd0;
      step();
   endtask

   task automatic test_goal();
      ball_x = 10'd628;
      step();
      checks++;
      if (bounce !== 2'b11 || score_l !== 4'd1 || point_l !== 1'b1 || point_r !== 1'b0) begin
         errors++;
         $display("FAIL goal_issue: bounce=%b sl=%0d pl=%b pr=%b expected 11/1/1/0",
                  bounce, score_l, point_l, point_r);
      end
      step();
      checks++;
      if (bounce !== 2'b11 || score_l !== 4'd1 || point_l !== 1'b0) begin
         errors++;
         $display("FAIL goal_pulse_width: bounce=%b sl=%0d pl=%b expected 11/1/0",
                  bounce, score_l, point_l);
      end
      ball_x = 10'd321;
      ball_y = 10'd241;
      step();
      checks++;
      if (bounce !== 2'b11 || game_over !== 1'b0) begin
         errors++;
         $display("FAIL goal_to_serve: bounce=%b go=%b expected 11/0", bounce, game_over);
      end
      serve_wait("goal");
   endtask

   task automatic test_game_over();
      for (int p = 0; p < 8; p++) begin
         ball_x = 10'd0;
         step();
         ball_x = 10'd320;
         step();
         serve_wait("rally");
      end
      checks++;
      if (score_r !== 4'd8 || score_l !== 4'd1) begin
         errors++;
         $display("FAIL score_accum: sl=%0d sr=%0d expected 1/8", score_l, score_r);
      end
      ball_x = 10'd0;
      step();
      checks++;
      if (score_r !== 4'd9 || point_r !== 1'b1 || bounce !== 2'b11 || game_over !== 1'b0) begin
         errors++;
         $display("FAIL win_point: sr=%0d pr=%b bounce=%b go=%b expected 9/1/11/0",
                  score_r, point_r, bounce, game_over);
      end
      ball_x = 10'd320;
      step();
      checks++;
      if (game_over !== 1'b1 || bounce !== 2'b11) begin
         errors++;
         $display("FAIL game_over_entry: go=%b bounce=%b expected 1/11", game_over, bounce);
      end
      for (int i = 0; i < 3; i++) begin
         ball_x = 10'(100 + 50 * i);
         step();
      end
      checks++;
      if (game_over !== 1'b1 || bounce !== 2'b11 || score_r !== 4'd9) begin
         errors++;
         $display("FAIL game_over_park: go=%b bounce=%b sr=%0d expected 1/11/9", game_over, bounce, score_r);
      end
      ball_x = 10'd320;
      start = 1'b1;
      step();
      start = 1'b0;
      checks++;
      if (score_l !== 4'd0 || score_r !== 4'd0 || game_over !== 1'b0 || bounce !== 2'b11) begin
         errors++;
         $display("FAIL restart: sl=%0d sr=%0d go=%b bounce=%b expected 0/0/0/11",
                  score_l, score_r, game_over, bounce);
      end
      // A start pulse mid-serve must not restart the pause.
      step();
      step();
      start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < 4; i++) step();
      checks++;
      if (bounce !== 2'b11) begin
         errors++;
         $display("FAIL serve_start_ignored_hold: bounce=%b expected 11", bounce);
      end
      step();
      checks++;
      if (bounce !== 2'b00) begin
         errors++;
         $display("FAIL serve_start_ignored_release: bounce=%b expected 00", bounce);
      end
   endtask

   task automatic test_corner_reset();
      ball_x = 10'd628;
      step();
      ball_x = 10'd320;
      step();
      serve_wait("corner_pre");
      ball_x = 10'd28;
      ball_y = 10'd2;
      paddle_l_y = 10'd0;
      step();
      checks++;
      if (bounce !== 2'b01) begin
         errors++;
         $display("FAIL corner_paddle_first: bounce=%b expected 01", bounce);
      end
      ball_x = 10'd29;
      step();
      checks++;
      if (bounce !== 2'b00) begin
         errors++;
         $display("FAIL corner_consume: bounce=%b expected 00", bounce);
      end
      step();
      checks++;
      if (bounce !== 2'b10 || score_l !== 4'd1) begin
         errors++;
         $display("FAIL corner_wall_next: bounce=%b sl=%0d expected 10/1", bounce, score_l);
      end
      reset = 1'b1;
      step();
      checks++;
      if ({bounce, score_l, score_r, point_l, point_r, game_over} !== {2'b11, 4'd0, 4'd0, 3'b000}) begin
         errors++;
         $display("FAIL reset_mid_hold: bounce=%b sl=%0d sr=%0d pl=%b pr=%b go=%b expected 11/0/0/0/0/0",
                  bounce, score_l, score_r, point_l, point_r, game_over);
      end
      reset = 1'b0;
      ball_x = 10'd0;
      step();
      step();
      checks++;
      if (bounce !== 2'b11 || score_r !== 4'd0 || point_r !== 1'b0) begin
         errors++;
         $display("FAIL idle_after_reset: bounce=%b sr=%0d pr=%b expected 11/0/0", bounce, score_r, point_r);
      end
   endtask

   initial begin
      test_reset();
      test_serve();
      test_wall();
      test_paddle();
      test_goal();
      test_game_over();
      test_corner_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
